// File: rtl/sd_cmd_pkg.sv
// SD command frame shared definitions: widths, CRC7 polynomial, FSM states.
// CRC7 step helper used by the serial CRC register.
package sd_cmd_pkg;

  localparam int CMD_HEAD_W  = 40;
  localparam int CMD_CRC_W   = 7;
  localparam int CMD_FRAME_W = 48;

  localparam logic [CMD_CRC_W-1:0] CRC7_POLY = 7'h09;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_DATA = 3'd1;
  localparam state_t ST_CRC  = 3'd2;
  localparam state_t ST_END  = 3'd3;
  localparam state_t ST_NCC  = 3'd4;
  localparam state_t ST_DONE = 3'd5;

  function automatic logic [CMD_CRC_W-1:0] crc7_step(
    input logic [CMD_CRC_W-1:0] crc,
    input logic                 b
  );
    crc7_step = {crc[5:0], 1'b0} ^ ((b ^ crc[6]) ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/cmd_frame_tx_if.sv
// Handshake and line bundle between command controller and CMD transmitter.
// master = controller side, slave = transmitter side.
interface cmd_frame_tx_if
  import sd_cmd_pkg::*;
;
  logic                  strobe_in;
  logic [CMD_HEAD_W-1:0] cmd_in;
  logic                  ack_in;
  logic                  busy;
  logic                  done_out;
  logic                  cmd_pin_out;
  logic                  cmd_oe;
  logic [CMD_CRC_W-1:0]  crc_out;

  modport master (
    output strobe_in, cmd_in, ack_in,
    input  busy, done_out, cmd_pin_out, cmd_oe, crc_out
  );

  modport slave (
    input  strobe_in, cmd_in, ack_in,
    output busy, done_out, cmd_pin_out, cmd_oe, crc_out
  );
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 register (x^7+x^3+1). Clear with enable seeds from zero
// and absorbs the data bit in the same cycle.
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic                 bit_i,
  output logic [CMD_CRC_W-1:0] crc_o
);

  logic [CMD_CRC_W-1:0] crc_q, crc_d, base;

  always_comb begin
    base  = clr_i ? '0 : crc_q;
    crc_d = base;
    if (en_i) crc_d = crc7_step(base, bit_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) crc_q <= '0;
    else         crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/cmd_frame_tx.sv
// SD CMD-line frame transmitter: 40-bit head, CRC7, end bit, N_CC idle.
// CRC7 generation is built only when CMD_CRC7_EN is defined.
module cmd_frame_tx
  import sd_cmd_pkg::*;
#(
  parameter int unsigned NCC_CYCLES = 8
) (
  input logic           clk_SD,
  input logic           reset_host,
  cmd_frame_tx_if.slave bus
);

  localparam logic [7:0] NCC_LAST = 8'(NCC_CYCLES - 1);

  state_t                state_q, state_d;
  logic [CMD_HEAD_W-2:0] shreg_q, shreg_d;
  logic [CMD_CRC_W-1:0]  sh_q, sh_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  pin_q, pin_d;
  logic                  oe_q, oe_d;
  logic                  done_q, done_d;
  logic [CMD_CRC_W-1:0]  crc_cur;

  wire load    = (state_q == ST_IDLE) && bus.strobe_in;
  wire data_end = (state_q == ST_DATA) && (cnt_q == 8'd39);

`ifdef CMD_CRC7_EN
  logic                 crc_en, crc_bit;
  logic [CMD_CRC_W-1:0] crc_out_q;

  // CRC absorbs each bit as it is loaded onto the line, so it is final
  // by the last data cycle.
  assign crc_en  = load || ((state_q == ST_DATA) && (cnt_q < 8'd39));
  assign crc_bit = load ? bus.cmd_in[CMD_HEAD_W-1] : shreg_q[CMD_HEAD_W-2];

  sd_crc7 u_crc (
    .clk_i  (clk_SD),
    .rst_ni (reset_host),
    .clr_i  (load),
    .en_i   (crc_en),
    .bit_i  (crc_bit),
    .crc_o  (crc_cur)
  );

  always_ff @(posedge clk_SD) begin
    if (!reset_host)   crc_out_q <= '0;
    else if (data_end) crc_out_q <= crc_cur;
  end

  assign bus.crc_out = crc_out_q;
`else
  assign crc_cur     = '1;
  assign bus.crc_out = '0;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    pin_d   = pin_q;
    oe_d    = oe_q;
    done_d  = done_q;
    unique case (state_q)
      ST_IDLE: begin
        pin_d = 1'b1;
        oe_d  = 1'b0;
        if (bus.strobe_in) begin
          shreg_d = bus.cmd_in[CMD_HEAD_W-2:0];
          cnt_d   = '0;
          pin_d   = bus.cmd_in[CMD_HEAD_W-1];
          oe_d    = 1'b1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        shreg_d = {shreg_q[CMD_HEAD_W-3:0], 1'b0};
        pin_d   = shreg_q[CMD_HEAD_W-2];
        cnt_d   = cnt_q + 8'd1;
        if (cnt_q == 8'd39) begin
          sh_d    = crc_cur;
          pin_d   = crc_cur[6];
          cnt_d   = '0;
          state_d = ST_CRC;
        end
      end
      ST_CRC: begin
        sh_d  = {sh_q[5:0], 1'b0};
        pin_d = sh_q[5];
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd6) begin
          pin_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_END;
        end
      end
      ST_END: begin
        pin_d   = 1'b1;
        oe_d    = 1'b0;
        cnt_d   = '0;
        state_d = ST_NCC;
      end
      ST_NCC: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == NCC_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.ack_in) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_SD) begin
    if (!reset_host) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      pin_q   <= 1'b1;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      pin_q   <= pin_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done_out    = done_q;
  assign bus.cmd_pin_out = pin_q;
  assign bus.cmd_oe      = oe_q;

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Self-checking bench for cmd_frame_tx against a frame-level reference model.
// Expected CRC comes from polynomial long division of the head.
module tb_cmd_frame_tx;
  import sd_cmd_pkg::*;

  localparam int NCC = 8;

  logic clk_SD     = 1'b0;
  logic reset_host = 1'b0;
  int   total = 0;
  int   bad   = 0;

  cmd_frame_tx_if bus ();

  cmd_frame_tx #(.NCC_CYCLES(NCC)) dut (
    .clk_SD     (clk_SD),
    .reset_host (reset_host),
    .bus        (bus)
  );

  always #5 clk_SD = ~clk_SD;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_crc(input logic [39:0] h);
    logic [46:0] r;
    r = {h, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  function automatic logic [47:0] ref_frame(input logic [39:0] h);
`ifdef CMD_CRC7_EN
    return {h, ref_crc(h), 1'b1};
`else
    return {h, 8'hFF};
`endif
  endfunction

  function automatic logic [6:0] ref_crc_out(input logic [39:0] h);
`ifdef CMD_CRC7_EN
    return ref_crc(h);
`else
    return 7'h00;
`endif
  endfunction

  function automatic logic [39:0] rnd_head();
    logic [39:0] r;
    r = {8'($urandom), 32'($urandom)};
    return r;
  endfunction

  task automatic step();
    @(posedge clk_SD);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done_out), 64'd0);
    chk({tag, "_pin"},  64'(bus.cmd_pin_out), 64'd1);
    chk({tag, "_oe"},   64'(bus.cmd_oe), 64'd0);
  endtask

  // Sends one frame; checks every cycle from 1 through 49+NCC+hold.
  task automatic run_frame(input logic [39:0] h, input int hold,
                           input bit perturb, input int abort_at);
    logic [47:0] f;
    f = ref_frame(h);
    bus.cmd_in    = h;
    bus.strobe_in = 1'b1;
    for (int c = 1; c <= 49 + NCC + hold; c++) begin
      step();
      if (c == 1) bus.strobe_in = 1'b0;
      chk("busy", 64'(bus.busy), 64'd1);
      if (c <= 48) begin
        chk("oe_frame", 64'(bus.cmd_oe), 64'd1);
        chk($sformatf("pin_c%0d", c), 64'(bus.cmd_pin_out),
            64'(f[48-c]));
      end else begin
        chk("oe_idle", 64'(bus.cmd_oe), 64'd0);
        chk("pin_idle", 64'(bus.cmd_pin_out), 64'd1);
      end
      if (c >= 41)
        chk("crc_out", 64'(bus.crc_out), 64'(ref_crc_out(h)));
      chk($sformatf("done_c%0d", c), 64'(bus.done_out),
          64'(c >= 49 + NCC));
      if (perturb && c == 5)  bus.cmd_in = rnd_head();
      if (perturb && c == 10) bus.strobe_in = 1'b1;
      if (perturb && c == 11) bus.strobe_in = 1'b0;
      if (perturb && c == 50) bus.ack_in = 1'b1;
      if (perturb && c == 52) bus.ack_in = 1'b0;
      if (c == abort_at) begin
        reset_host = 1'b0;
        step();
        chk_idle("abort");
        chk("abort_crc", 64'(bus.crc_out), 64'd0);
        reset_host = 1'b1;
        return;
      end
    end
  endtask

  task automatic do_ack();
    bus.ack_in = 1'b1;
    step();
    bus.ack_in = 1'b0;
    chk_idle("ack");
  endtask

  initial begin
    logic [39:0] h;
    bus.strobe_in = 1'b0;
    bus.ack_in    = 1'b0;
    bus.cmd_in    = '0;
    reset_host    = 1'b0;
    step();
    step();
    chk_idle("reset");
    chk("reset_crc", 64'(bus.crc_out), 64'd0);
    reset_host = 1'b1;
    step();
    chk_idle("post_reset");

    // CMD0: done held 20 cycles (57..77), ack at 77
    run_frame(40'h4000000000, 20, 1'b0, 0);
    do_ack();

    // CMD17: strobe with ack in DONE is not queued
    run_frame(40'h5100000000, 0, 1'b0, 0);
    bus.strobe_in = 1'b1;
    bus.ack_in    = 1'b1;
    step();
    bus.strobe_in = 1'b0;
    bus.ack_in    = 1'b0;
    chk_idle("ack_strobe");
    step();
    chk_idle("no_queue");

    // CMD8 with mid-frame cmd change, stray strobe and early ack
    run_frame(40'h48000001AA, 2, 1'b1, 0);
    h = rnd_head();
    bus.cmd_in    = h;
    bus.strobe_in = 1'b1;
    bus.ack_in    = 1'b1;
    step();
    bus.ack_in = 1'b0;
    chk_idle("held_strobe");
    // strobe still high: frame starts from the first IDLE cycle
    run_frame(h, 0, 1'b0, 0);
    do_ack();

    for (int i = 0; i < 3; i++) begin
      run_frame(rnd_head(), i, 1'b0, 0);
      do_ack();
    end

    run_frame(rnd_head(), 0, 1'b0, 20);
    step();
    chk_idle("after_abort");
    run_frame(40'h4000000000, 0, 1'b0, 0);
    do_ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_frame_tx.md
# cmd_frame_tx

Serial transmitter for SD command frames on the CMD line, clocked by `clk_SD`. It accepts the 40-bit command head (start bit, transmission bit, index, argument) from the command controller. It computes CRC7 on the fly, shifts the full 48-bit frame out MSB-first, drives the end bit, and holds the line high for N_CC cycles. It then reports completion through a strobe/ack handshake and sits in place of a plain parallel-to-serial stage.

## Interface
- `NCC_CYCLES`, default 8: idle-high cycles after the end bit before `done_out` is raised; legal range 1–255.
- `clk_SD`  in  1: SD clock; the only clock; all logic is on the rising edge.
- `reset_host`  in  1: synchronous, active-low reset.
- `strobe_in`  in  1: transmit request, sampled in IDLE only.
- `cmd_in`  in  40: frame bits [47:8], sent as is with no check of bits 39/38.
- `ack_in`  in  1: completion acknowledge, sampled in DONE only.
- `busy`  out  1: high in every state except IDLE.
- `done_out`  out  1: frame and N_CC period complete; held until acked.
- `cmd_pin_out`  out  1: registered CMD line value.
- `cmd_oe`  out  1: registered output enable; high while frame bits are driven.
- `crc_out`  out  7: CRC7 of the last frame; valid from the first CRC bit cycle until the next load.

## Operation
- Reset values (reset_host low at an edge): state IDLE, `busy`=0, `done_out`=0, `cmd_pin_out`=1, `cmd_oe`=0, `crc_out`=0, bit counter=0.
- Reset mid-frame aborts at once: the next cycle shows the reset values. No partial-frame completion is reported.
- States and transitions:
  - IDLE: pin=1, oe=0. On `strobe_in`=1, capture `cmd_in` into the shift register, clear CRC and counter, go to DATA.
  - DATA: 40 cycles. Drive shreg[39] and shift left. The CRC is updated with the driven bit. After count 39, go to CRC.
  - CRC: 7 cycles. Drive crc[6] and shift the CRC left, filling with 0. Then go to END.
  - END: 1 cycle, pin=1, oe=1. Then go to NCC.
  - NCC: NCC_CYCLES cycles, pin=1, oe=0. Then go to DONE.
  - DONE: `done_out`=1, pin=1, oe=0. On `ack_in`=1, go to IDLE.
- CRC7 uses polynomial x^7+x^3+1 with init 0:
  - fb = bit ^ crc[6]
  - crc_next = {crc[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00)
- `crc_out` holds the full CRC captured at the DATA→CRC transition. It does not follow the shifting copy.
- Boundary rules:
  - `strobe_in` outside IDLE is ignored; no queueing.
  - `cmd_in` changes after capture are ignored.
  - `strobe_in` and `ack_in` high together in DONE: only the ack is honoured, and the request must be re-presented in IDLE.
  - `ack_in` outside DONE is ignored.
  - `strobe_in` held high through DONE→IDLE starts a new frame in the first IDLE cycle.

## Timing
- Take the cycle in which `strobe_in` is sampled in IDLE as cycle 0.
- Cycles 1–48: `cmd_oe`=1.
  - `cmd_pin_out` = frame bit 47 at cycle 1, down to bit 0 (end bit, =1) at cycle 48.
  - The CRC occupies cycles 41–47.
- Cycles 49 … 48+NCC_CYCLES: oe=0, pin=1.
- Cycle 49+NCC_CYCLES: `done_out` rises.
- An ack seen at cycle N puts IDLE (done_out=0, busy=0) at N+1.
- Minimum frame-to-frame spacing is 50+NCC_CYCLES cycles.
- `busy` rises at cycle 1.

## Configuration
- `CMD_CRC7_EN` defined: CRC7 is computed as above and `crc_out` is live.
- `CMD_CRC7_EN` not defined:
  - The CRC logic is removed.
  - The 7 CRC cycles drive 7'h7F (line high, oe=1).
  - `crc_out` is tied to 0.
  - Timing is unchanged.

## Structure
- Shared package `sd_cmd_pkg`:
  - State enum.
  - `CRC7_POLY`=7'h09.
  - `CMD_HEAD_W`=40, `CMD_CRC_W`=7, `CMD_FRAME_W`=48.
- Sub-module `sd_crc7`: serial CRC7 register with clear, enable and data bit inputs and a 7-bit output. It is instantiated only under `CMD_CRC7_EN`.

## Test plan
- CMD0, arg 0: `cmd_in`=40'h4000000000 → line carries 48'h400000000095 on cycles 1–48; `crc_out`=7'h4A.
- CMD17, arg 0: 40'h5100000000 → last byte 8'h55, `crc_out`=7'h2A. CMD8, arg 0x1AA: 40'h48000001AA → last byte 8'h87, `crc_out`=7'h43.
- NCC_CYCLES=8, no ack → `done_out` rises at cycle 57 and stays high 20 cycles. Ack at cycle 77 → IDLE at 78, and `busy`=0 at 78.
- `strobe_in` pulsed at cycle 10 and `cmd_in` changed at cycle 5 mid-frame → both ignored; the frame is bit-identical to the original capture.
- `reset_host` low at cycle 20 → at cycle 21 pin=1, oe=0, busy=0, done_out=0. A new strobe then sends a clean full frame.
- Build without `CMD_CRC7_EN`, CMD0 → line 48'h4000000000FF; `crc_out`=0; `done_out` timing identical to the CRC build.
